// File: rtl/mxrv_wb_ctrl_pkg.sv
// Writeback controller shared types and constants.
// Register/data widths, reset level and grant encodings.
package mxrv_wb_ctrl_pkg;

  localparam int RegAddrW = 5;
  localparam int DataW    = 32;
  localparam int NumRegs  = 32;

  localparam logic RstEnable = 1'b0;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [DataW-1:0]    data_t;
  typedef logic [NumRegs-1:0]  sb_t;

  localparam data_t ZeroWord = '0;

  typedef enum logic {
    GNT_EX  = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  // x0 never holds a pending write, so index 0 never hits.
  function automatic logic sb_hit(
    input sb_t       b,
    input reg_addr_t i
  );
    return (i != '0) && b[i];
  endfunction

  function automatic sb_t sb_onehot(
    input logic      en,
    input reg_addr_t i
  );
    sb_t m;
    m = '0;
    if (en && (i != '0))
      m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mxrv_wb_ctrl_if.sv
// Issue, writer and regfile bundle for the writeback controller.
// master drives requests, slave is the controller.
interface mxrv_wb_ctrl_if;
  import mxrv_wb_ctrl_pkg::*;

  logic      issue_valid_i;
  reg_addr_t issue_rd_i;
  reg_addr_t issue_rs1_i;
  reg_addr_t issue_rs2_i;
  logic      issue_stall_o;

  logic      ex_valid_i;
  reg_addr_t ex_rd_i;
  data_t     ex_data_i;
  logic      ex_ready_o;

  logic      lsu_valid_i;
  reg_addr_t lsu_rd_i;
  data_t     lsu_data_i;
  logic      lsu_ready_o;

  logic      we_o;
  reg_addr_t rd_addr_o;
  data_t     rd_data_o;

  logic      flush_i;
  sb_t       busy_o;

  modport master (
    output issue_valid_i,
    output issue_rd_i,
    output issue_rs1_i,
    output issue_rs2_i,
    input  issue_stall_o,
    output ex_valid_i,
    output ex_rd_i,
    output ex_data_i,
    input  ex_ready_o,
    output lsu_valid_i,
    output lsu_rd_i,
    output lsu_data_i,
    input  lsu_ready_o,
    input  we_o,
    input  rd_addr_o,
    input  rd_data_o,
    output flush_i,
    input  busy_o
  );

  modport slave (
    input  issue_valid_i,
    input  issue_rd_i,
    input  issue_rs1_i,
    input  issue_rs2_i,
    output issue_stall_o,
    input  ex_valid_i,
    input  ex_rd_i,
    input  ex_data_i,
    output ex_ready_o,
    input  lsu_valid_i,
    input  lsu_rd_i,
    input  lsu_data_i,
    output lsu_ready_o,
    output we_o,
    output rd_addr_o,
    output rd_data_o,
    input  flush_i,
    output busy_o
  );

endinterface

// File: rtl/mxrv_rr_arb2.sv
// Two-requester round-robin arbiter (EX vs LSU).
// Grants are combinational; last_grant moves only on a grant.
module mxrv_rr_arb2
  import mxrv_wb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ex,
  input  logic req_lsu,
  output logic gnt_ex,
  output logic gnt_lsu
);

  gnt_e last_q;
  gnt_e last_d;

  always_comb begin
    gnt_ex  = 1'b0;
    gnt_lsu = 1'b0;
    unique case (1'b1)
      (req_ex && req_lsu): begin
        if (last_q == GNT_LSU)
          gnt_ex = 1'b1;
        else
          gnt_lsu = 1'b1;
      end
      (req_ex && !req_lsu): gnt_ex  = 1'b1;
      (!req_ex && req_lsu): gnt_lsu = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    last_d = last_q;
    unique case (1'b1)
      gnt_ex:  last_d = GNT_EX;
      gnt_lsu: last_d = GNT_LSU;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable)
      last_q <= GNT_LSU;
    else
      last_q <= last_d;
  end

endmodule

// File: rtl/mxrv_wb_ctrl.sv
// Writeback controller: scoreboard, hazard stall, EX/LSU
// arbitration and registered regfile write port.
module mxrv_wb_ctrl
  import mxrv_wb_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  mxrv_wb_ctrl_if.slave wb
);

  sb_t       busy_q;
  sb_t       busy_d;
  sb_t       set_m;
  sb_t       clr_m;
  logic      gnt_ex;
  logic      gnt_lsu;
  logic      gnt_any;
  reg_addr_t gnt_rd;
  data_t     gnt_data;
  logic      stall;
  logic      reserve;
  logic      we_q;
  reg_addr_t addr_q;
  data_t     data_q;

  mxrv_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_ex  (wb.ex_valid_i),
    .req_lsu (wb.lsu_valid_i),
    .gnt_ex  (gnt_ex),
    .gnt_lsu (gnt_lsu)
  );

  assign gnt_any = gnt_ex | gnt_lsu;

  always_comb begin
    gnt_rd   = '0;
    gnt_data = ZeroWord;
    unique case (1'b1)
      gnt_ex: begin
        gnt_rd   = wb.ex_rd_i;
        gnt_data = wb.ex_data_i;
      end
      gnt_lsu: begin
        gnt_rd   = wb.lsu_rd_i;
        gnt_data = wb.lsu_data_i;
      end
      default: ;
    endcase
  end

  // Stalling on busy[rd] also rules out reserve/release of one reg.
  assign stall = wb.issue_valid_i &
                 (sb_hit(busy_q, wb.issue_rs1_i) |
                  sb_hit(busy_q, wb.issue_rs2_i) |
                  sb_hit(busy_q, wb.issue_rd_i));

  assign reserve = wb.issue_valid_i & ~stall & ~wb.flush_i;

  always_comb begin
    set_m  = sb_onehot(reserve, wb.issue_rd_i);
    clr_m  = sb_onehot(gnt_any, gnt_rd);
    busy_d = (busy_q & ~clr_m) | set_m;
    if (wb.flush_i)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      busy_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= ZeroWord;
    end else begin
      busy_q <= busy_d;
      we_q   <= gnt_any & (gnt_rd != '0);
      if (gnt_any) begin
        addr_q <= gnt_rd;
        data_q <= gnt_data;
      end
    end
  end

  assign wb.issue_stall_o = stall;
  assign wb.ex_ready_o    = gnt_ex;
  assign wb.lsu_ready_o   = gnt_lsu;
  assign wb.we_o          = we_q;
  assign wb.rd_addr_o     = addr_q;
  assign wb.rd_data_o     = data_q;
  assign wb.busy_o        = busy_q;

endmodule

// File: tb/tb_mxrv_wb_ctrl.sv
// Directed bench for mxrv_wb_ctrl: per-cycle vector table
// plus reset and contention sequences.
module tb_mxrv_wb_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mxrv_wb_ctrl_if bus ();

  mxrv_wb_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          iv;
    bit [4:0]    ird;
    bit [4:0]    irs1;
    bit [4:0]    irs2;
    bit          exv;
    bit [4:0]    exrd;
    bit [31:0]   exd;
    bit          lv;
    bit [4:0]    lrd;
    bit [31:0]   ld;
    bit          fl;
    bit          e_stall;
    bit          e_exr;
    bit          e_lr;
    bit [31:0]   e_busy;
    bit          e_we;
    bit [4:0]    e_addr;
    bit [31:0]   e_data;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
    bus.issue_rs1_i   = '0;
    bus.issue_rs2_i   = '0;
    bus.ex_valid_i    = 1'b0;
    bus.ex_rd_i       = '0;
    bus.ex_data_i     = '0;
    bus.lsu_valid_i   = 1'b0;
    bus.lsu_rd_i      = '0;
    bus.lsu_data_i    = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic add(
    input bit rs, input bit iv, input bit [4:0] ird,
    input bit [4:0] irs1, input bit [4:0] irs2,
    input bit exv, input bit [4:0] exrd, input bit [31:0] exd,
    input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
    input bit fl, input bit st, input bit exr, input bit lr,
    input bit [31:0] busy, input bit we, input bit [4:0] a,
    input bit [31:0] d);
    vec_t v;
    v.rst_n = rs; v.iv = iv; v.ird = ird;
    v.irs1 = irs1; v.irs2 = irs2;
    v.exv = exv; v.exrd = exrd; v.exd = exd;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.fl = fl;
    v.e_stall = st; v.e_exr = exr; v.e_lr = lr;
    v.e_busy = busy; v.e_we = we; v.e_addr = a; v.e_data = d;
    vq.push_back(v);
  endtask

  initial begin
    vec_t v;
    bit   m_ex;
    int   ecnt;
    int   lcnt;
    logic [4:0]  erd;
    logic [4:0]  lrd;
    logic [4:0]  g_rd;
    logic [31:0] g_d;

    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy_o, 32'h0);
    chk("rst_we", {31'b0, bus.we_o}, 32'h0);
    chk("rst_addr", {27'b0, bus.rd_addr_o}, 32'h0);
    chk("rst_data", bus.rd_data_o, 32'h0);

    //  rs iv ird rs1 rs2 exv exrd exd lv lrd ld fl | st exr lr busy we a d
    add(1,1,5,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h20, 0,0,0);
    add(1,1,6,5,0, 0,0,0, 0,0,0, 0, 1,0,0, 32'h20, 0,0,0);
    add(1,1,6,5,0, 1,5,32'h1111_1111, 0,0,0, 0,
        1,1,0, 32'h0, 1,5,32'h1111_1111);
    add(1,1,8,5,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h100, 0,0,0);
    add(0,1,7,0,0, 1,1,32'hA1A1_0001, 1,2,32'hB2B2_0002, 0,
        0,0,1, 32'h0, 0,0,0);
    add(1,0,0,0,0, 1,1,32'hA1A1_0001, 1,2,32'hB2B2_0002, 0,
        0,1,0, 32'h0, 1,1,32'hA1A1_0001);
    add(1,0,0,0,0, 1,3,32'hA3A3_0003, 1,2,32'hB2B2_0002, 0,
        0,0,1, 32'h0, 1,2,32'hB2B2_0002);
    add(1,0,0,0,0, 1,3,32'hA3A3_0003, 1,4,32'hB4B4_0004, 0,
        0,1,0, 32'h0, 1,3,32'hA3A3_0003);
    add(1,0,0,0,0, 1,5,32'hA5A5_0005, 1,4,32'hB4B4_0004, 0,
        0,0,1, 32'h0, 1,4,32'hB4B4_0004);
    add(1,0,0,0,0, 1,5,32'hA5A5_0005, 0,0,0, 0,
        0,1,0, 32'h0, 1,5,32'hA5A5_0005);
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h0, 0,0,0);
    add(1,1,0,0,0, 1,0,32'hDEAD_BEEF, 0,0,0, 0,
        0,1,0, 32'h0, 0,0,0);
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h0, 0,0,0);
    add(1,1,5,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h20, 0,0,0);
    add(1,1,7,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'hA0, 0,0,0);
    add(1,1,3,0,0, 0,0,0, 1,7,32'h77, 1,
        0,0,1, 32'h0, 1,7,32'h77);
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h0, 0,0,0);
    add(1,1,4,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h10, 0,0,0);
    add(1,1,9,1,0, 0,0,0, 1,4,32'h44, 0,
        0,0,1, 32'h200, 1,4,32'h44);
    add(1,0,0,0,0, 1,9,32'h99, 0,0,0, 0,
        0,1,0, 32'h0, 1,9,32'h99);
    add(1,1,10,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h400, 0,0,0);
    add(0,0,0,0,0, 1,11,32'hC0C0_000B, 1,12,32'hD0D0_000C, 0,
        0,0,1, 32'h0, 0,0,0);
    add(1,0,0,0,0, 1,11,32'hC0C0_000B, 1,12,32'hD0D0_000C, 0,
        0,1,0, 32'h0, 1,11,32'hC0C0_000B);
    add(1,0,0,0,0, 0,0,0, 1,12,32'hD0D0_000C, 0,
        0,0,1, 32'h0, 1,12,32'hD0D0_000C);
    add(1,1,13,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 32'h2000, 0,0,0);
    add(1,1,2,0,13, 0,0,0, 0,0,0, 0, 1,0,0, 32'h2000, 0,0,0);
    add(1,1,13,0,0, 0,0,0, 0,0,0, 0, 1,0,0, 32'h2000, 0,0,0);
    add(1,0,13,0,13, 0,0,0, 0,0,0, 0, 0,0,0, 32'h2000, 0,0,0);

    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      rst_n             = v.rst_n;
      bus.issue_valid_i = v.iv;
      bus.issue_rd_i    = v.ird;
      bus.issue_rs1_i   = v.irs1;
      bus.issue_rs2_i   = v.irs2;
      bus.ex_valid_i    = v.exv;
      bus.ex_rd_i       = v.exrd;
      bus.ex_data_i     = v.exd;
      bus.lsu_valid_i   = v.lv;
      bus.lsu_rd_i      = v.lrd;
      bus.lsu_data_i    = v.ld;
      bus.flush_i       = v.fl;
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, bus.issue_stall_o},
          {31'b0, v.e_stall});
      chk($sformatf("v%0d_ex_ready", i), {31'b0, bus.ex_ready_o},
          {31'b0, v.e_exr});
      chk($sformatf("v%0d_lsu_ready", i), {31'b0, bus.lsu_ready_o},
          {31'b0, v.e_lr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), bus.busy_o, v.e_busy);
      chk($sformatf("v%0d_we", i), {31'b0, bus.we_o},
          {31'b0, v.e_we});
      if (v.e_we) begin
        chk($sformatf("v%0d_addr", i), {27'b0, bus.rd_addr_o},
            {27'b0, v.e_addr});
        chk($sformatf("v%0d_data", i), bus.rd_data_o, v.e_data);
      end
    end

    // Reset with both writers pending and busy nonzero.
    @(negedge clk);
    idle_inputs();
    rst_n            = 1'b0;
    bus.ex_valid_i   = 1'b1;
    bus.ex_rd_i      = 5'd20;
    bus.ex_data_i    = 32'h2020_2020;
    bus.lsu_valid_i  = 1'b1;
    bus.lsu_rd_i     = 5'd21;
    bus.lsu_data_i   = 32'h2121_2121;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", bus.busy_o, 32'h0);
    chk("mid_rst_we", {31'b0, bus.we_o}, 32'h0);
    chk("mid_rst_addr", {27'b0, bus.rd_addr_o}, 32'h0);
    chk("mid_rst_data", bus.rd_data_o, 32'h0);

    // Continuous contention: strict alternation starting with EX.
    m_ex = 1'b1;
    ecnt = 0;
    lcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      erd = 5'(1 + ecnt);
      lrd = 5'(16 + lcnt);
      bus.ex_rd_i    = erd;
      bus.ex_data_i  = {24'hE0E0E0, 3'b0, erd};
      bus.lsu_rd_i   = lrd;
      bus.lsu_data_i = {24'hF0F0F0, 3'b0, lrd};
      g_rd = m_ex ? erd : lrd;
      g_d  = m_ex ? bus.ex_data_i : bus.lsu_data_i;
      #1;
      chk($sformatf("rr%0d_ex_ready", i), {31'b0, bus.ex_ready_o},
          {31'b0, m_ex});
      chk($sformatf("rr%0d_lsu_ready", i), {31'b0, bus.lsu_ready_o},
          {31'b0, !m_ex});
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_we", i), {31'b0, bus.we_o}, 32'h1);
      chk($sformatf("rr%0d_addr", i), {27'b0, bus.rd_addr_o},
          {27'b0, g_rd});
      chk($sformatf("rr%0d_data", i), bus.rd_data_o, g_d);
      if (m_ex) ecnt++;
      else      lcnt++;
      m_ex = !m_ex;
    end

    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("tail_we", {31'b0, bus.we_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mxrv_wb_ctrl.md
MXRV_WB_CTRL -- requirements
Module: mxrv_wb_ctrl

Interface
REQ-001 Clock and reset: clk input 1, rising-edge clock; rst_n input 1, reset, synchronous, active-low.
REQ-002 Issue side: issue_valid_i input 1, id issuing an instruction this cycle; issue_rd_i input 5, destination reg; issue_rs1_i, issue_rs2_i input 5 each, source regs; issue_stall_o output 1, hazard stall to id.
REQ-003 EX writer: ex_valid_i input 1, writeback request; ex_rd_i input 5; ex_data_i input 32; ex_ready_o output 1, grant.
REQ-004 LSU writer: lsu_valid_i input 1; lsu_rd_i input 5; lsu_data_i input 32; lsu_ready_o output 1, grant.
REQ-005 Regfile write port: we_o output 1; rd_addr_o output 5; rd_data_o output 32; drives the regfile we_i, rd_addr_i and rd_data_i.
REQ-006 Control and status: flush_i input 1, pipeline flush; busy_o output 32, scoreboard bit vector, bit n set means xn has a pending write.

Function
REQ-007 Scoreboard: busy[31:0] register; bit 0 SHALL read 0 at all times.
REQ-008 issue_stall_o is combinational: issue_valid_i AND (busy[rs1] OR busy[rs2] OR busy[rd]), evaluated on the current busy value; a nonzero index is required for any term to contribute.
REQ-009 Reservation: at a clock edge with issue_valid_i=1, issue_stall_o=0, flush_i=0 and issue_rd_i≠0, busy[issue_rd_i] is set.
REQ-010 Arbitration: at most one grant per cycle; ex_ready_o and lsu_ready_o are combinational from the valids and the last_grant register.
REQ-011 With a single requester valid, that requester is granted.
REQ-012 With both requesters valid, the requester not granted last is granted (round-robin); last_grant resets to LSU, so EX wins the first tie.
REQ-013 last_grant is updated only on a cycle in which a grant occurs.
REQ-014 Handshake: a requester holds valid, rd and data stable until its ready is seen high; the transfer completes at that clock edge.
REQ-015 Latency: a grant at edge N produces we_o=1, rd_addr_o=granted rd and rd_data_o=granted data, registered, during cycle N+1; we_o is 0 in every cycle not preceded by a grant.
REQ-016 Writes to x0 are granted normally (the requester is consumed), but we_o stays 0 for them.
REQ-017 Release: at a grant edge, busy[granted rd] is cleared.
REQ-018 Simultaneous release and reservation of different regs apply together.
REQ-019 Reservation of the same reg being released is impossible, because REQ-008 stalls on busy[rd].
REQ-020 flush_i=1 clears all busy bits at the edge and blocks reservation that cycle.
REQ-021 Arbitration and writeback continue unaffected during flush; a release of a reg already cleared by flush is harmless.
REQ-022 No internal queueing: a requester not granted simply waits, and there is no starvation, bounded to 1 cycle under continuous contention.

Reset
REQ-023 On a clk edge with rst_n=0, the following SHALL reset: busy=0, last_grant=LSU, we_o=0, rd_addr_o=0, rd_data_o=0.
REQ-024 Reset overrides any grant, reservation or flush in the same cycle.
REQ-025 A writeback granted in the reset cycle is lost.
REQ-026 Ready outputs follow REQ-010 from the current register values, including during reset.

Structure
REQ-027 Register address width (5), data width (32, ZeroWord), RstEnable and the grant encodings (GNT_EX, GNT_LSU) belong in the shared defines file.
REQ-028 One sub-module is natural: mxrv_rr_arb2, the 2-requester round-robin arbiter holding last_grant.
REQ-029 The scoreboard and output registers stay in mxrv_wb_ctrl.

Verification
REQ-030 Reserve and stall: issue rd=5, then next cycle issue rs1=5 -> issue_stall_o=1, busy_o=0x20; EX writes x5 -> busy_o=0 one edge later, stall drops.
REQ-031 Contention: EX and LSU valid continuously for 4 cycles -> grants EX, LSU, EX, LSU; we_o follows one cycle behind each grant with matching rd and data.
REQ-032 x0: EX writes rd=0, data=0xDEADBEEF -> ex_ready_o=1 and we_o stays 0; issue rd=0 -> busy_o unchanged, no stall.
REQ-033 Flush: busy_o=0x0000_00A0 and flush_i pulsed with issue rd=3 -> busy_o=0 and x3 is not reserved; pending LSU write to x7 still emits we_o=1, rd_addr_o=7.
REQ-034 Reset mid-operation: rst_n=0 while both requesters valid and busy_o≠0 -> after the edge busy_o=0, we_o=0, and the next tie grants EX.
REQ-035 Same-cycle release and reserve: LSU releases x4 while id reserves x9 -> busy_o goes 0x10 -> 0x200.
